// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Weighted bursts are enabled by defining WRR_ARBITER_WEIGHT_EN.
package wrr_arbiter_pkg;

  localparam int WRR_N_DEF = 8;
  localparam int WRR_W_DEF = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } wrr_state_e;

  // A programmed weight of zero still grants one transfer.
  function automatic logic [31:0] wrr_eff_weight(input logic [31:0] w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/wrr_arbiter_pick.sv
// Rotating-priority picker: first set req bit at or above ptr, wrapping to 0.
// Built as a double-width masked priority encoder.
module wrr_pick
  import wrr_arbiter_pkg::*;
#(
  parameter int N  = WRR_N_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;

  // NOTE: every output of a combinational block gets a default first,
  // otherwise paths that skip an assignment infer a latch.
  always_comb begin
    mask  = '0;
    dbl   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    // Lower copy holds bits at/above ptr, upper copy supplies the wrap-around.
    dbl   = {req, req & mask};
    found = |req;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl[i]) begin
        idx = (i >= N) ? IW'(i - N) : IW'(i);
      end
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with grant/ack handshake and registered outputs.
// Define WRR_ARBITER_WEIGHT_EN for weighted bursts; otherwise every ack releases.
module wrr_arbiter
  import wrr_arbiter_pkg::*;
#(
  parameter int N  = WRR_N_DEF,
  parameter int W  = WRR_W_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] weight,
  input  logic           ack,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IW-1:0]  grant_idx
);

  wrr_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  credit_q, credit_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] idx_q, idx_d;

  logic          release_now;
  logic [IW-1:0] next_ptr;
  logic [IW-1:0] pick_ptr;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [W-1:0]  load_credit;
  logic [N-1:0]  pick_onehot;

  assign next_ptr    = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
  assign release_now = (state_q == GRANT) &&
                       (!req[idx_q] || (ack && (credit_q <= W'(1))));
  // On release, arbitrate with the advanced pointer so handover has no bubble.
  assign pick_ptr    = release_now ? next_ptr : ptr_q;

  wrr_pick #(.N(N), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef WRR_ARBITER_WEIGHT_EN
  assign load_credit = W'(wrr_eff_weight(32'(weight[int'(pick_idx)*W +: W])));
`else
  logic unused_weight;
  assign unused_weight = ^weight;
  assign load_credit   = W'(1);
`endif

  always_comb begin
    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    if ((state_q == IDLE) || release_now) begin
      if (release_now) ptr_d = next_ptr;
      if (pick_found) begin
        grant_d  = pick_onehot;
        idx_d    = pick_idx;
        credit_d = load_credit;
        state_d  = GRANT;
      end else begin
        grant_d  = '0;
        idx_d    = '0;
        credit_d = '0;
        state_d  = IDLE;
      end
    end else if (ack && (credit_q > W'(1))) begin
      credit_d = credit_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      credit_q <= '0;
      grant_q  <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_idx   = idx_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed self-checking bench for wrr_arbiter (N=4, W=4); expectations
// follow WRR_ARBITER_WEIGHT_EN when it is defined.
module tb_wrr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] weight;
  logic        ack;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [1:0]  grant_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_burst[8];
  int exp_stall[2];

  wrr_arbiter #(.N(4), .W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .weight      (weight),
    .ack         (ack),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_grant(input string tag, input int i);
    logic [31:0] oh;
    oh = 32'd1 << i;
    check({tag, "_grant"}, 32'(grant), oh);
    check({tag, "_valid"}, 32'(grant_valid), 32'd1);
    check({tag, "_idx"}, 32'(grant_idx), 32'(i));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_valid"}, 32'(grant_valid), 32'd0);
    check({tag, "_idx"}, 32'(grant_idx), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef WRR_ARBITER_WEIGHT_EN
    exp_burst = '{1, 1, 2, 2, 2, 3, 0, 1};
    exp_stall = '{1, 2};
`else
    exp_burst = '{1, 2, 3, 0, 1, 2, 3, 0};
    exp_stall = '{2, 1};
`endif

    // Reset and idle, then first grant one cycle after release.
    reset  = 1'b0;
    req    = 4'b1111;
    ack    = 1'b0;
    weight = {4'd1, 4'd3, 4'd2, 4'd1};
    repeat (2) step();
    expect_idle("reset");
    reset = 1'b1;
    step();
    expect_grant("first", 0);

    // Back-to-back bursts with ack held high.
    ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      expect_grant($sformatf("burst%0d", k), exp_burst[k]);
    end

    // Asynchronous reset mid-burst, observed before any clock edge.
    #2 reset = 1'b0;
    #1 expect_idle("async_rst");
    step();

    // Abandon: requester 2 drops before any ack, grant moves to 3.
    req   = 4'b0100;
    ack   = 1'b0;
    reset = 1'b1;
    step();
    expect_grant("abandon_g2", 2);
    req = 4'b1000;
    step();
    expect_grant("abandon_g3", 3);

    // Ack stall with a mid-burst weight change that must be ignored.
    reset = 1'b0;
    step();
    reset  = 1'b1;
    req    = 4'b0110;
    weight = {4'd1, 4'd3, 4'd2, 4'd1};
    step();
    expect_grant("stall_start", 1);
    weight = {4'd1, 4'd3, 4'd1, 4'd1};
    for (int k = 0; k < 5; k++) begin
      step();
      expect_grant($sformatf("stall%0d", k), 1);
    end
    ack = 1'b1;
    step();
    expect_grant("stall_ack0", exp_stall[0]);
    step();
    expect_grant("stall_ack1", exp_stall[1]);

    // Single requester with weight 0: every ack re-grants without a gap.
    reset = 1'b0;
    step();
    reset  = 1'b1;
    req    = 4'b0100;
    weight = {4'd1, 4'd0, 4'd1, 4'd1};
    step();
    expect_grant("single_start", 2);
    for (int k = 0; k < 4; k++) begin
      step();
      expect_grant($sformatf("single%0d", k), 2);
    end

    // Release to idle, ack ignored while idle, then wrap from ptr 3 to 0.
    req = 4'b0000;
    step();
    expect_idle("to_idle");
    step();
    expect_idle("idle_ack");
    req = 4'b0001;
    step();
    expect_grant("wrap", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
